// File: rtl/yuv422_packer.sv
// yuv422_packer: pairs 4:4:4 YUV pixels into packed YUYV 4:2:2 words.
// Ports: clk, rst (async, active-high); y/u/v, in_valid, in_eol, in_ready
// (pixel input); out_data {V,Y1,U,Y0}, out_eol, out_valid, out_ready (word output).
module yuv422_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  y,
    input  logic [7:0]  u,
    input  logic [7:0]  v,
    input  logic        in_valid,
    input  logic        in_eol,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_eol,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } phase_t;

    phase_t     phase;
    logic [7:0] y0_q;
    logic [7:0] u0_q;
    logic [7:0] v0_q;

    logic       out_space;
    logic       accept;
    logic       load;
    logic [7:0] u_avg;
    logic [7:0] v_avg;

    // Round-half-up mean of two offset-128 chroma samples; 9-bit sum,
    // so the result always fits in 8 bits.
    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
    endfunction

    assign out_space = !out_valid || out_ready;

    // A non-eol first-of-pair pixel only fills the hold registers, so it
    // never needs output space; everything else loads the output register.
    assign in_ready = (phase == EVEN && !in_eol) ? 1'b1 : out_space;
    assign accept   = in_valid && in_ready;
    assign load     = accept && (phase == ODD || in_eol);

    assign u_avg = avg8(u0_q, u);
    assign v_avg = avg8(v0_q, v);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= EVEN;
            y0_q      <= 8'h00;
            u0_q      <= 8'h00;
            v0_q      <= 8'h00;
            out_data  <= 32'h0;
            out_eol   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                unique case (phase)
                    EVEN: begin
                        if (!in_eol) begin
                            y0_q  <= y;
                            u0_q  <= u;
                            v0_q  <= v;
                            phase <= ODD;
                        end
                    end
                    ODD: begin
                        phase <= EVEN;
                    end
                    default: phase <= EVEN;
                endcase
            end

            if (load) begin
                if (phase == ODD) begin
                    out_data <= {v_avg, y, u_avg, y0_q};
                    out_eol  <= in_eol;
                end else begin
                    // Lone last pixel of an odd-length line: duplicate it.
                    out_data <= {v, y, u, y};
                    out_eol  <= 1'b1;
                end
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_yuv422_packer.sv
// tb_yuv422_packer: scoreboard bench for yuv422_packer.
// Drives pixels, models the expected YUYV words and checks every output word.
module tb_yuv422_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  y;
    logic [7:0]  u;
    logic [7:0]  v;
    logic        in_valid;
    logic        in_eol;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_eol;
    logic        out_valid;
    logic        out_ready;

    yuv422_packer dut (
        .clk       (clk),
        .rst       (rst),
        .y         (y),
        .u         (u),
        .v         (v),
        .in_valid  (in_valid),
        .in_eol    (in_eol),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_words  = 0;
    int stalls   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    bit have_last = 0;
    bit stream_on = 0;

    logic [32:0] exp_q[$];

    // reference model state
    bit         m_odd = 0;
    logic [7:0] m_y, m_u, m_v;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_avg(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return s[7:0];
    endfunction

    task automatic model_accept(input logic [7:0] py, input logic [7:0] pu,
                                input logic [7:0] pv, input logic pe);
        if (m_odd) begin
            exp_q.push_back({pe, ref_avg(m_v, pv), py, ref_avg(m_u, pu), m_y});
            m_odd = 0;
        end else if (!pe) begin
            m_y = py;
            m_u = pu;
            m_v = pv;
            m_odd = 1;
        end else begin
            exp_q.push_back({1'b1, pv, py, pu, py});
        end
    endtask

    // Presents one pixel and returns at posedge+1 of the accepting edge,
    // with in_valid still asserted.
    task automatic drive_pixel(input logic [7:0] py, input logic [7:0] pu,
                               input logic [7:0] pv, input logic pe);
        bit done;
        done = 0;
        y = py;
        u = pu;
        v = pv;
        in_eol = pe;
        in_valid = 1'b1;
        for (int w = 0; w < 50 && !done; w++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(py, pu, pv, pe);
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_eol = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: a word leaves at the edge following this negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", 64'(exp_q.size()), 64'd1);
            end else begin
                check("word", {31'd0, out_eol, out_data}, {31'd0, exp_q.pop_front()});
            end
            n_words++;
            if (stream_on && have_last) check("word_gap", 64'(cyc - last_cyc), 64'd2);
            last_cyc = cyc;
            have_last = 1;
        end
    end

    initial begin
        int s0;
        int w0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_eol = 1'b0;
        y = 8'd0;
        u = 8'd0;
        v = 8'd0;
        out_ready = 1'b1;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_eol", 64'(out_eol), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset in the middle of a pair discards the held pixel
        drive_pixel(8'd200, 8'd10, 8'd20, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        m_odd = 0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic pair
        drive_pixel(8'd76, 8'd84, 8'd255, 1'b0);
        drive_pixel(8'd29, 8'd255, 8'd107, 1'b0);
        in_valid = 1'b0;
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_data", 64'(out_data), 64'hB51DAA4C);
        check("basic_eol", 64'(out_eol), 64'd0);
        idle(2);

        // odd-length line pad, then a fresh pair with odd chroma sums
        drive_pixel(8'd149, 8'd43, 8'd21, 1'b1);
        in_valid = 1'b0;
        check("pad_data", 64'(out_data), 64'h15952B95);
        check("pad_eol", 64'(out_eol), 64'd1);
        drive_pixel(8'd10, 8'd10, 8'd200, 1'b0);
        drive_pixel(8'd20, 8'd11, 8'd201, 1'b0);
        in_valid = 1'b0;
        check("round_data", 64'(out_data), 64'hC9140B0A);
        idle(2);

        // even-length line end
        drive_pixel(8'd0, 8'd128, 8'd128, 1'b0);
        drive_pixel(8'd255, 8'd128, 8'd128, 1'b1);
        in_valid = 1'b0;
        check("eol_data", 64'(out_data), 64'h80FF8000);
        check("eol_eol", 64'(out_eol), 64'd1);
        idle(2);

        // backpressure
        out_ready = 1'b0;
        drive_pixel(8'd76, 8'd84, 8'd255, 1'b0);
        drive_pixel(8'd29, 8'd255, 8'd107, 1'b0);
        in_valid = 1'b0;
        check("bp_first", 64'(out_data), 64'hB51DAA4C);
        drive_pixel(8'd50, 8'd60, 8'd70, 1'b0);
        y = 8'd90;
        u = 8'd61;
        v = 8'd71;
        in_eol = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold_data", 64'(out_data), 64'hB51DAA4C);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        if (in_ready) model_accept(8'd90, 8'd61, 8'd71, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_new_valid", 64'(out_valid), 64'd1);
        check("bp_new_data", 64'(out_data), 64'h475A3D32);
        idle(2);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // back-to-back stream
        s0 = stalls;
        w0 = n_words;
        have_last = 0;
        stream_on = 1;
        for (int i = 0; i < 16; i++) begin
            drive_pixel(8'($urandom_range(255)), 8'($urandom_range(255)),
                        8'($urandom_range(255)), (i == 15));
        end
        in_valid = 1'b0;
        check("stream_stalls", 64'(stalls - s0), 64'd0);
        idle(2);
        stream_on = 0;
        check("stream_words", 64'(n_words - w0), 64'd8);

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) idle(1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/yuv422_packer.md
# yuv422_packer

Streaming stage directly downstream of the RGB-to-YUV converter. Accepts one 4:4:4 YUV pixel per handshake, pairs adjacent pixels, averages their chroma and emits one packed 32-bit YUYV (4:2:2) word per pair toward the frame-buffer/DMA writer. Halves chroma bandwidth and pads odd-length lines so each output line is a whole number of words.

## Interface
- No parameters; all widths fixed (8-bit components, 32-bit word).
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- y, u, v  input  8 each  pixel from the converter; u and v are offset-128.
- in_valid  input  1  pixel on y/u/v/in_eol is valid.
- in_eol  input  1  pixel is the last pixel of its line.
- in_ready  output  1  stage can accept the presented pixel this cycle.
- out_data  output  32  packed word {V, Y1, U, Y0}; byte 0 is Y0.
- out_eol  output  1  word contains the last pixel of a line.
- out_valid  output  1  out_data/out_eol valid.
- out_ready  input  1  downstream accepts the word this cycle.

## Operation
- Two-state FSM on the pixel-pair phase:
  - EVEN: no pixel held.
  - ODD: first pixel of a pair held in y0_q/u0_q/v0_q.
- Input handshake: a pixel is taken when in_valid && in_ready. Output handshake: a word is consumed when out_valid && out_ready.
- out_space = !out_valid || out_ready. The output register can be loaded this cycle.
- in_ready: in EVEN with in_eol=0, it is 1 unconditionally. In ODD, or in EVEN with in_eol=1, it equals out_space. This is a combinational dependency on in_eol, which is intentional.
- EVEN, accepted pixel, in_eol=0: capture y/u/v into the hold registers and go to ODD. Output unchanged.
- ODD, accepted pixel, any in_eol: load the output register and go to EVEN.
  - Y0 = y0_q, Y1 = y.
  - U = (u0_q + u + 1) >> 1 and V = (v0_q + v + 1) >> 1, using 9-bit sums with round-half-up. The result can never exceed 255, so there is no saturation.
  - out_eol = in_eol.
- EVEN, accepted pixel, in_eol=1 (odd-length line): pad immediately. Load the output register with Y0 = Y1 = y, U = u, V = v and out_eol = 1, then stay in EVEN.
- out_valid is set when the output register loads. It clears on an output handshake with no simultaneous load.
- Simultaneous output consume and new load in one cycle: the new word replaces the old one and out_valid stays 1. There is no bubble.
- Held-pixel registers change only on an EVEN-phase non-eol capture. out_data/out_eol are held stable while out_valid && !out_ready.
- The phase does not care about frame boundaries. Line alignment comes only from in_eol.

## Timing
- Reset (asynchronous, any cycle, including mid-pair): phase=EVEN, out_valid=0, out_data=32'h0, out_eol=0, hold registers=0. A half-received pair is discarded.
- While rst is high, in_ready follows the EVEN rule (1 when in_eol=0). Pixels are not captured until rst falls.
- Latency: a word is valid on the cycle after the clock edge that accepted the second pixel of the pair (or the padded eol pixel).
- Throughput: 1 pixel/cycle sustained with out_ready=1, giving 1 word per 2 cycles.
- Backpressure: with out_valid=1 and out_ready=0, one more first-of-pair pixel is still accepted. The following pixel stalls with in_ready=0 until out_ready=1.

## Test plan
- Reset: assert rst mid-pair (phase ODD) -> out_valid=0, out_data=0, next pair starts fresh; held pixel never appears in output.
- Basic pair: (Y=76,U=84,V=255) then (Y=29,U=255,V=107), in_eol=0, out_ready=1 -> one cycle after second accept, out_valid=1, out_data=32'hB51DAA4C, out_eol=0.
- Odd-length line: single pixel (Y=149,U=43,V=21) with in_eol=1 in EVEN -> out_data=32'h15952B95, out_eol=1; phase remains EVEN; next pixel starts a new pair.
- Even-length line end: pair (Y=0,U=128,V=128), (Y=255,U=128,V=128) with in_eol=1 on second pixel -> out_data=32'h80FF8000, out_eol=1.
- Backpressure: hold out_ready=0 after first word; feed 2 more pixels -> first accepted, second sees in_ready=0 and out_data stays 32'hB51DAA4C; raise out_ready -> second accepted same cycle, new word valid next cycle, no word lost or duplicated.
- Streaming: 16 random pixels at in_valid=1, out_ready=1 -> 8 words, one every 2 cycles; each word matches the reference model including the +1 rounding on odd chroma sums (e.g. U 10,11 -> 11).
